// File: rtl/acc_apb_master.sv
`default_nettype none
// ============================================================================
// Module  : acc_apb_master
// Brief   : Command/response to APB initiator with a PREADY wait-state watchdog.
// Revision: 1.0
// ============================================================================
module acc_apb_master #(
    parameter int APB_ADDR_WIDTH = 13,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit C_WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic                      wdog_hit;

    // Completion has priority: the watchdog only fires on a PREADY-low cycle.
    assign wdog_hit = C_WDOG_EN && (cnt_q == C_LIMIT) && !PREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : 32'd0;
                end else if (wdog_hit) begin
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (C_WDOG_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus controls are registered copies of the state being entered.
        psel_d      = (state_d != ST_IDLE);
        penable_d   = (state_d == ST_ACCESS);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_apb_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_acc_apb_master
// Brief   : Randomised self-checking bench for acc_apb_master against a timing model.
// Revision: 1.0
// ============================================================================
module tb_acc_apb_master;

    localparam int AW = 13;
    localparam int TO = 4;

    logic          HCLK;
    logic          HRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int total = 0;
    int bad   = 0;

    acc_apb_master #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // What one transfer looked like, cycles counted from the accept cycle (0).
    typedef struct {
        int          lat;
        bit          err;
        bit          tmo;
        logic [31:0] rdata;
        int          psel_first;
        int          pen_first;
        int          sel_cycles;
        int          pen_cycles;
        bit          stable;
        bit          ready_busy;
        int          pulse;
        bit          ready_at_rsp;
    } obs_t;

    // Expected transfer outcome from the command and the slave's wait count.
    function automatic obs_t model(input bit wr, input int waits, input logic [31:0] prd,
                                   input bit perr);
        obs_t e;
        if (TO != 0 && waits > TO) begin
            e.lat = TO + 3; e.err = 1'b1; e.tmo = 1'b1; e.rdata = 32'd0;
        end else begin
            e.lat = 3 + waits; e.err = perr; e.tmo = 1'b0;
            e.rdata = (!wr && !perr) ? prd : 32'd0;
        end
        e.psel_first = 1; e.pen_first = 2;
        e.sel_cycles = e.lat - 1; e.pen_cycles = e.lat - 2;
        e.stable = 1'b1; e.ready_busy = 1'b0; e.pulse = 1; e.ready_at_rsp = 1'b1;
        return e;
    endfunction

    // Issues one command from IDLE and plays an APB slave inserting `waits` wait states.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] prd, input bit perr,
                           output obs_t o);
        int acc_idx;
        o.lat = -1; o.err = 0; o.tmo = 0; o.rdata = '0; o.psel_first = -1; o.pen_first = -1;
        o.sel_cycles = 0; o.pen_cycles = 0; o.stable = 1; o.ready_busy = 0; o.pulse = 0;
        o.ready_at_rsp = 0;
        acc_idx = 0;
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        PREADY = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge HCLK);
            if (k == 1) begin
                cmd_valid = 1'b0; cmd_write = 1'($urandom);
                cmd_addr = AW'($urandom); cmd_wdata = $urandom;
            end
            if (PSEL) begin
                o.sel_cycles++;
                if (o.psel_first < 0) o.psel_first = k;
                if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd) o.stable = 0;
            end
            if (PENABLE) begin
                o.pen_cycles++;
                if (o.pen_first < 0) o.pen_first = k;
            end
            if (rsp_valid) begin
                o.pulse++;
                if (o.lat < 0) begin
                    o.lat = k; o.err = rsp_err; o.tmo = rsp_timeout; o.rdata = rsp_rdata;
                    o.ready_at_rsp = cmd_ready;
                end
            end
            if (o.lat < 0 && cmd_ready) o.ready_busy = 1;
            if (o.lat >= 0 && k > o.lat) break;
            if (PSEL && PENABLE) begin
                PREADY = (acc_idx >= waits);
                acc_idx++;
            end else begin
                PREADY = 1'($urandom);
            end
            if (PREADY && PSEL && PENABLE) begin
                PRDATA = prd; PSLVERR = perr;
            end else begin
                PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL reset_psel got=%b want=0", PSEL); end
        total++; if (PENABLE !== 1'b0) begin bad++; $display("FAIL reset_penable got=%b want=0", PENABLE); end
        total++; if (PWRITE !== 1'b0) begin bad++; $display("FAIL reset_pwrite got=%b want=0", PWRITE); end
        total++; if (PADDR !== '0) begin bad++; $display("FAIL reset_paddr got=%h want=0", PADDR); end
        total++; if (PWDATA !== '0) begin bad++; $display("FAIL reset_pwdata got=%h want=0", PWDATA); end
        total++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0) begin
            bad++; $display("FAIL reset_rsp got=%b%b%b/%h want=000/0", rsp_valid, rsp_err,
                            rsp_timeout, rsp_rdata);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        obs_t o, e;
        logic [31:0] prd;
        prd = $urandom;
        run_txn(1'b1, 13'h000, 32'h1, 0, prd, 1'b0, o);
        e = model(1'b1, 0, prd, 1'b0);
        total++; if (o.lat !== e.lat) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", o.lat, e.lat); end
        total++; if (o.psel_first !== 1) begin bad++; $display("FAIL wr_psel_first got=%0d want=1", o.psel_first); end
        total++; if (o.pen_first !== 2 || o.pen_cycles !== 1) begin
            bad++; $display("FAIL wr_penable got=%0d/%0d want=2/1", o.pen_first, o.pen_cycles); end
        total++; if (o.sel_cycles !== 2) begin bad++; $display("FAIL wr_psel_cycles got=%0d want=2", o.sel_cycles); end
        total++; if (o.stable !== 1'b1) begin bad++; $display("FAIL wr_stable got=%b want=1", o.stable); end
        total++; if (o.err !== 1'b0 || o.rdata !== 32'd0) begin
            bad++; $display("FAIL wr_rsp got=%b/%h want=0/0", o.err, o.rdata); end
        total++; if (o.pulse !== 1) begin bad++; $display("FAIL wr_pulse got=%0d want=1", o.pulse); end
        total++; if (o.ready_busy !== 1'b0 || o.ready_at_rsp !== 1'b1) begin
            bad++; $display("FAIL wr_ready got=%b/%b want=0/1", o.ready_busy, o.ready_at_rsp); end
        total++; if (PADDR !== 13'h000 || PWDATA !== 32'h1 || PWRITE !== 1'b1) begin
            bad++; $display("FAIL wr_idle_hold got=%h/%h/%b want=0/1/1", PADDR, PWDATA, PWRITE); end
    endtask

    task automatic test_read_wait();
        obs_t o;
        run_txn(1'b0, 13'h005, $urandom, 3, 32'h0001A2B3, 1'b0, o);
        total++; if (o.lat !== 6) begin bad++; $display("FAIL rd_latency got=%0d want=6", o.lat); end
        total++; if (o.rdata !== 32'h0001A2B3) begin bad++; $display("FAIL rd_data got=%h want=0001a2b3", o.rdata); end
        total++; if (o.sel_cycles !== 5 || o.stable !== 1'b1) begin
            bad++; $display("FAIL rd_stable got=%0d/%b want=5/1", o.sel_cycles, o.stable); end
        total++; if (o.err !== 1'b0 || o.tmo !== 1'b0) begin
            bad++; $display("FAIL rd_flags got=%b/%b want=0/0", o.err, o.tmo); end
    endtask

    task automatic test_slverr();
        obs_t o;
        run_txn(1'b0, 13'h0A0, $urandom, int'($urandom_range(0, 2)), 32'hFFFFFFFF, 1'b1, o);
        total++; if (o.err !== 1'b1 || o.tmo !== 1'b0) begin
            bad++; $display("FAIL slverr_flags got=%b/%b want=1/0", o.err, o.tmo); end
        total++; if (o.rdata !== 32'd0) begin bad++; $display("FAIL slverr_rdata got=%h want=0", o.rdata); end
    endtask

    task automatic test_timeout();
        obs_t o;
        logic [31:0] prd;
        run_txn(1'b0, 13'h1ABC, $urandom, 100, $urandom, 1'b0, o);
        total++; if (o.lat !== TO + 3) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", o.lat, TO + 3); end
        total++; if (o.err !== 1'b1 || o.tmo !== 1'b1 || o.rdata !== 32'd0) begin
            bad++; $display("FAIL tmo_rsp got=%b/%b/%h want=1/1/0", o.err, o.tmo, o.rdata); end
        total++; if (o.sel_cycles !== TO + 2) begin
            bad++; $display("FAIL tmo_psel_drop got=%0d want=%0d", o.sel_cycles, TO + 2); end
        prd = $urandom;
        run_txn(1'b0, 13'h0042, $urandom, TO, prd, 1'b0, o);
        total++; if (o.lat !== TO + 3 || o.tmo !== 1'b0 || o.rdata !== prd) begin
            bad++; $display("FAIL tmo_edge got=%0d/%b/%h want=%0d/0/%h", o.lat, o.tmo, o.rdata, TO + 3, prd); end
        run_txn(1'b1, 13'h0010, 32'hCAFE0001, 0, 32'd0, 1'b0, o);
        total++; if (o.lat !== 3 || o.err !== 1'b0) begin
            bad++; $display("FAIL tmo_recover got=%0d/%b want=3/0", o.lat, o.err); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h0123; cmd_wdata = 32'h5A5A5A5A;
        PREADY = 1'b0;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        @(negedge HCLK);
        total++; if (PENABLE !== 1'b1) begin bad++; $display("FAIL rstmid_access got=%b want=1", PENABLE); end
        #2 HRESETn = 1'b0;
        #1;
        total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            bad++; $display("FAIL rstmid_async got=%b%b want=00", PSEL, PENABLE); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        PREADY = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge HCLK);
            if (rsp_valid) seen = 1;
        end
        PREADY = 1'b0;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got=%b want=0", seen); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs[3];
        logic [31:0]   datas[3];
        int            rsp_k[$];
        logic [44:0]   setups[$];
        int            idx;
        bit            adv;
        addrs = '{13'd1, 13'd2, 13'd1};
        datas = '{32'h11, 32'h22, 32'h33};
        idx = 0; adv = 0;
        @(negedge HCLK);
        PREADY = 1'b1; PSLVERR = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addrs[0]; cmd_wdata = datas[0];
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) @(negedge HCLK);
            if (adv) begin
                adv = 0;
                if (idx < 3) begin cmd_addr = addrs[idx]; cmd_wdata = datas[idx]; end
                else cmd_valid = 1'b0;
            end
            if (rsp_valid) rsp_k.push_back(k);
            if (PSEL && !PENABLE) setups.push_back({PADDR, PWDATA});
            if (cmd_valid && cmd_ready) begin idx++; adv = 1; end
        end
        cmd_valid = 1'b0; PREADY = 1'b0;
        total++; if (rsp_k.size() !== 3) begin bad++; $display("FAIL b2b_rsp_count got=%0d want=3", rsp_k.size()); end
        for (int i = 0; i < 3 && i < rsp_k.size(); i++) begin
            total++; if (rsp_k[i] !== 3 * (i + 1)) begin
                bad++; $display("FAIL b2b_rsp_time[%0d] got=%0d want=%0d", i, rsp_k[i], 3 * (i + 1)); end
        end
        total++; if (setups.size() !== 3) begin bad++; $display("FAIL b2b_setup_count got=%0d want=3", setups.size()); end
        for (int i = 0; i < 3 && i < setups.size(); i++) begin
            total++; if (setups[i] !== {addrs[i], datas[i]}) begin
                bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, setups[i], {addrs[i], datas[i]}); end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        bit wr, perr;
        logic [AW-1:0] addr;
        logic [31:0] wd, prd;
        int waits;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom); perr = ($urandom_range(0, 3) == 0);
            addr = AW'($urandom); wd = $urandom; prd = $urandom;
            waits = int'($urandom_range(0, TO + 2));
            run_txn(wr, addr, wd, waits, prd, perr, o);
            e = model(wr, waits, prd, perr);
            total++; if (o.lat !== e.lat) begin
                bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, o.lat, e.lat); end
            total++; if (o.err !== e.err || o.tmo !== e.tmo) begin
                bad++; $display("FAIL rnd%0d_flags got=%b/%b want=%b/%b", n, o.err, o.tmo, e.err, e.tmo); end
            total++; if (o.rdata !== e.rdata) begin
                bad++; $display("FAIL rnd%0d_rdata got=%h want=%h", n, o.rdata, e.rdata); end
            total++; if (o.stable !== e.stable || o.pen_cycles !== e.pen_cycles) begin
                bad++; $display("FAIL rnd%0d_bus got=%b/%0d want=%b/%0d", n, o.stable, o.pen_cycles,
                                e.stable, e.pen_cycles); end
            total++; if (o.pulse !== e.pulse) begin
                bad++; $display("FAIL rnd%0d_pulse got=%0d want=%0d", n, o.pulse, e.pulse); end
        end
    endtask

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/acc_apb_master.md
# acc_apb_master

APB initiator that drives the matrix accelerator's APB slave port (and any other 8 KB APB slave in the subsystem) from a simple command/response interface. It converts one command into a standard two-phase APB transfer (SETUP, ACCESS with wait states) and returns read data and error status on a one-cycle response pulse. A wait-state watchdog aborts transfers whose slave never asserts PREADY. It sits between the test/host sequencer (A/X loading, enable, result readback) and the accelerator's PADDR/PWDATA/PSEL bus.

## Interface
- APB_ADDR_WIDTH, 13, width of PADDR and cmd_addr (8 KB slave window)
- TIMEOUT_CYCLES, 255, max ACCESS cycles with PREADY low before abort; 0 disables the watchdog
- HCLK  in  1  single clock, all logic rising-edge
- HRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts a command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  APB_ADDR_WIDTH  target address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  32  read data (0 for writes, errors and timeouts)
- rsp_err  out  1  PSLVERR seen or timeout, valid with rsp_valid
- rsp_timeout  out  1  transfer aborted by watchdog, valid with rsp_valid
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0; unconditionally go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE stable throughout SETUP and ACCESS.
  - PREADY=1: complete. Next cycle IDLE with rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0, rsp_rdata=PRDATA if read and PSLVERR=0, else 0.
  - PREADY=0: wait counter increments; stay ACCESS.
  - Counter reaching TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): abort. Next cycle IDLE, PSEL/PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- PREADY=1 on the same cycle the counter hits the limit: completion wins, no timeout.
- Wait counter clears on every entry to SETUP; width ceil(log2(TIMEOUT_CYCLES+1)), minimum 1 bit.
- PADDR/PWDATA/PWRITE hold their last value in IDLE.
- PSLVERR, PRDATA sampled only in ACCESS with PREADY=1; ignored otherwise.
- cmd_* ignored while cmd_ready=0; sender must hold them until accepted.

## Timing
- Reset (HRESETn low, asynchronous): state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=1 (after release), rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, counter=0.
- Reset mid-transfer: PSEL/PENABLE drop immediately; no response is ever issued for that command.
- Zero-wait transfer: accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid and cmd_ready at T+3. Throughput one command per 3 cycles with cmd_valid held high.
- Each PREADY-low cycle adds one cycle of latency.
- Timeout: rsp_valid exactly TIMEOUT_CYCLES+3 cycles after acceptance when PREADY stays low.
- rsp_valid is high for exactly one cycle; no backpressure on responses.

## Test plan
- Write addr 0x000 data 0x00000001 with PREADY tied 1 -> PSEL at T+1, PENABLE at T+2 only, PWDATA=1 stable both cycles, rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read addr 0x005, PREADY low for 3 ACCESS cycles then high with PRDATA=0x0001A2B3 -> rsp_valid at T+6, rsp_rdata=0x0001A2B3, PADDR stable T+1..T+5.
- Read with PSLVERR=1 at completion, PRDATA=0xFFFFFFFF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYCLES=4, PREADY held 0 -> abort, rsp_valid at T+7 with rsp_err=1, rsp_timeout=1; PSEL=0 same cycle; next command completes normally.
- HRESETn pulsed low during ACCESS -> PSEL/PENABLE 0 asynchronously, no rsp_valid, cmd_ready=1 after release.
- cmd_valid held high for writes to addr 1,2,1 (data 0x11,0x22,0x33), PREADY=1 -> three transfers in order, rsp_valid at T+3, T+6, T+9.
